beat_sequencer: RTL and testbench

Parametrised successor to the free-running beat counter that drives the note/tone lookup for game audio. Adds a per-beat clock prescaler, run-time track length, loop vs one-shot mode, pause/resume without losing position, and end-of-track signalling. Sits between game-state control (issues play/pause/stop) and the music ROM/tone generator, which consume ibeat.

---
 rtl/beat_seq_pkg.sv | 16 +
 rtl/beat_sequencer_prescaler.sv | 28 ++
 rtl/beat_sequencer.sv | 133 +++++++++++++
 tb/tb_beat_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beat_seq_pkg.sv
// Shared types and default widths for the beat sequencer.
// States, width defaults and the fallback track length used when len_i is 0.
package beat_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } beat_state_t;

   localparam int BEAT_W_DEF      = 12;
   localparam int DIV_W_DEF       = 16;
   localparam int DEFAULT_LEN_DEF = 4095;

endpackage

// File: rtl/beat_sequencer_prescaler.sv
// Per-beat clock prescaler: pcnt counts 0..div while run is high; tick marks the last count.
// clr has priority over run so a restart or seek always begins a fresh beat period.
module beat_prescaler
   import beat_seq_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] pcnt;

   assign tick = run && (pcnt == div);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         pcnt <= '0;
      end else if (run) begin
         pcnt <= tick ? '0 : pcnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/beat_sequencer.sv
// Beat sequencer: play/pause/stop FSM, per-run latching of len/div/loop and beat arithmetic.
// Optional seek support is built only when BEAT_SEQUENCER_SEEK_EN is defined.
module beat_sequencer
   import beat_seq_pkg::*;
#(
   parameter int BEAT_W      = BEAT_W_DEF,
   parameter int DIV_W       = DIV_W_DEF,
   parameter int DEFAULT_LEN = DEFAULT_LEN_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_i,
   input  logic              pause_i,
   input  logic              stop_i,
   input  logic              loop_i,
   input  logic [BEAT_W-1:0] len_i,
   input  logic [DIV_W-1:0]  div_i,
   output logic [BEAT_W-1:0] ibeat,
   output logic              beat_stb,
   output logic              wrap_stb,
   output logic              done,
   output logic              playing
`ifdef BEAT_SEQUENCER_SEEK_EN
   ,
   input  logic              seek_i,
   input  logic [BEAT_W-1:0] seek_beat_i
`endif
);

   beat_state_t       state_q, state_d;
   logic [BEAT_W-1:0] ibeat_d, len_q, len_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              loop_q, loop_d;
   logic              beat_stb_d, wrap_stb_d, done_d;
   logic              start, seek_hit, run, clr, tick;
   logic [BEAT_W:0]   beat_inc;

   assign start = play_i && ((state_q == IDLE) || (state_q == DONE));

`ifdef BEAT_SEQUENCER_SEEK_EN
   assign seek_hit = seek_i && ((state_q == PLAY) || (state_q == PAUSE));
`else
   assign seek_hit = 1'b0;
`endif

   // The resume cycle already counts toward the held beat period.
   assign run = !stop_i && !seek_hit &&
                (((state_q == PLAY) && !pause_i) || ((state_q == PAUSE) && play_i));
   assign clr = stop_i || seek_hit || start;

   assign beat_inc = {1'b0, ibeat} + (BEAT_W + 1)'(1);

   beat_prescaler #(.DIV_W(DIV_W)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .clr   (clr),
      .div   (div_q),
      .tick  (tick)
   );

   always_comb begin
      state_d    = state_q;
      ibeat_d    = ibeat;
      len_d      = len_q;
      div_d      = div_q;
      loop_d     = loop_q;
      beat_stb_d = 1'b0;
      wrap_stb_d = 1'b0;
      done_d     = 1'b0;

      if (stop_i) begin
         state_d = IDLE;
         ibeat_d = '0;
`ifdef BEAT_SEQUENCER_SEEK_EN
      end else if (seek_hit) begin
         ibeat_d    = (seek_beat_i < len_q) ? seek_beat_i : len_q - BEAT_W'(1);
         beat_stb_d = 1'b1;
`endif
      end else if (start) begin
         state_d = PLAY;
         ibeat_d = '0;
         len_d   = (len_i == '0) ? BEAT_W'(DEFAULT_LEN) : len_i;
         div_d   = div_i;
         loop_d  = loop_i;
      end else if ((state_q == PLAY) && pause_i) begin
         state_d = PAUSE;
      end else if ((state_q == PAUSE) && play_i) begin
         state_d = PLAY;
      end

      // tick is only ever high in a cycle that ends in PLAY.
      if (tick) begin
         if (beat_inc < {1'b0, len_q}) begin
            ibeat_d    = beat_inc[BEAT_W-1:0];
            beat_stb_d = 1'b1;
         end else if (loop_q) begin
            ibeat_d    = '0;
            beat_stb_d = 1'b1;
            wrap_stb_d = 1'b1;
         end else begin
            ibeat_d = '0;
            state_d = DONE;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ibeat    <= '0;
         len_q    <= '0;
         div_q    <= '0;
         loop_q   <= 1'b0;
         beat_stb <= 1'b0;
         wrap_stb <= 1'b0;
         done     <= 1'b0;
         playing  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ibeat    <= ibeat_d;
         len_q    <= len_d;
         div_q    <= div_d;
         loop_q   <= loop_d;
         beat_stb <= beat_stb_d;
         wrap_stb <= wrap_stb_d;
         done     <= done_d;
         playing  <= (state_d == PLAY);
      end
   end

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: expected {ibeat, beat_stb, wrap_stb, done, playing} per cycle
// is queued as stimulus is driven and compared one cycle later, #1 after the clock edge.
module tb_beat_sequencer;

   localparam int BW = 12;
   localparam int DW = 16;
   localparam int W  = BW + 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          play_i, pause_i, stop_i, loop_i;
   logic [BW-1:0] len_i;
   logic [DW-1:0] div_i;
   logic [BW-1:0] ibeat;
   logic          beat_stb, wrap_stb, done, playing;
`ifdef BEAT_SEQUENCER_SEEK_EN
   logic          seek_i;
   logic [BW-1:0] seek_beat_i;
`endif

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got, want;
   int checks   = 0;
   int failures = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   beat_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .play_i      (play_i),
      .pause_i     (pause_i),
      .stop_i      (stop_i),
      .loop_i      (loop_i),
      .len_i       (len_i),
      .div_i       (div_i),
      .ibeat       (ibeat),
      .beat_stb    (beat_stb),
      .wrap_stb    (wrap_stb),
      .done        (done),
      .playing     (playing)
`ifdef BEAT_SEQUENCER_SEEK_EN
      ,
      .seek_i      (seek_i),
      .seek_beat_i (seek_beat_i)
`endif
   );

   function automatic logic [W-1:0] mk(int b, bit s, bit w, bit d, bit p);
      return {BW'(b), s, w, d, p};
   endfunction

   function automatic logic [W-1:0] obs();
      return {ibeat, beat_stb, wrap_stb, done, playing};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setup(int len, int div, bit lp);
      len_i  = BW'(len);
      div_i  = DW'(div);
      loop_i = lp;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      play_i = 0; pause_i = 0; stop_i = 0;
      setup(0, 0, 0);
`ifdef BEAT_SEQUENCER_SEEK_EN
      seek_i = 0; seek_beat_i = '0;
`endif
      step(); step();
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL reset_state got=%h want=%h", got, want); end
      reset = 1'b0;
      step();
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL idle_after_reset got=%h want=%h", got, want); end
   endtask

   task automatic test_loop();
      setup(5, 0, 1);
      play_i = 1;
      exp_q.push_back(mk(0, 0, 0, 0, 1));
      for (int k = 1; k <= 6; k++)
         exp_q.push_back(mk(k % 5, 1, (k == 5), 0, 1));
      for (int i = 0; i < 7; i++) begin
         step();
         play_i = 0;
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin failures++; $display("FAIL loop5 cyc=%0d got=%h want=%h", i, got, want); end
      end
      stop_i = 1;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      step();
      stop_i = 0;
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL loop5_stop got=%h want=%h", got, want); end
      // length 1 in loop mode wraps on every tick
      setup(1, 0, 1);
      play_i = 1;
      exp_q.push_back(mk(0, 0, 0, 0, 1));
      for (int k = 0; k < 3; k++) exp_q.push_back(mk(0, 1, 1, 0, 1));
      for (int i = 0; i < 4; i++) begin
         step();
         play_i = 0;
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin failures++; $display("FAIL len1_loop cyc=%0d got=%h want=%h", i, got, want); end
      end
      stop_i = 1;
      step();
      stop_i = 0;
   endtask

   task automatic test_oneshot();
      setup(3, 3, 0);
      play_i = 1;
      for (int b = 0; b < 3; b++) begin
         exp_q.push_back(mk(b, (b != 0), 0, 0, 1));
         for (int h = 0; h < 3; h++) exp_q.push_back(mk(b, 0, 0, 0, 1));
      end
      exp_q.push_back(mk(0, 0, 0, 1, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      for (int i = 0; i < 15; i++) begin
         step();
         play_i = 0;
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin failures++; $display("FAIL oneshot3 cyc=%0d got=%h want=%h", i, got, want); end
      end
      // length 1 one-shot finishes on the first tick
      setup(1, 0, 0);
      play_i = 1;
      exp_q.push_back(mk(0, 0, 0, 0, 1));
      exp_q.push_back(mk(0, 0, 0, 1, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         step();
         play_i = 0;
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin failures++; $display("FAIL len1_oneshot cyc=%0d got=%h want=%h", i, got, want); end
      end
   endtask

   task automatic test_pause_resume();
      // Starts from DONE; reach ibeat=2 with pcnt=1 (9 edges after the play edge).
      setup(8, 3, 1);
      play_i = 1;
      for (int i = 0; i <= 9; i++)
         exp_q.push_back(mk(i / 4, (i == 4 || i == 8), 0, 0, 1));
      for (int i = 0; i <= 9; i++) begin
         step();
         play_i = 0;
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin failures++; $display("FAIL pre_pause cyc=%0d got=%h want=%h", i, got, want); end
      end
      pause_i = 1;
      for (int i = 0; i < 11; i++) exp_q.push_back(mk(2, 0, 0, 0, 0));
      for (int i = 0; i < 11; i++) begin
         step();
         pause_i = 0;
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin failures++; $display("FAIL paused cyc=%0d got=%h want=%h", i, got, want); end
      end
      play_i = 1;
      exp_q.push_back(mk(2, 0, 0, 0, 1));
      exp_q.push_back(mk(2, 0, 0, 0, 1));
      exp_q.push_back(mk(3, 1, 0, 0, 1));
      for (int i = 0; i < 3; i++) begin
         step();
         play_i = 0;
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin failures++; $display("FAIL resume cyc=%0d got=%h want=%h", i, got, want); end
      end
   endtask

   task automatic test_priority();
      // In PLAY: all three commands together -> stop wins, no done.
      play_i = 1; pause_i = 1; stop_i = 1;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      for (int i = 0; i < 2; i++) begin
         step();
         play_i = 0; pause_i = 0; stop_i = 0;
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin failures++; $display("FAIL stop_prio cyc=%0d got=%h want=%h", i, got, want); end
      end
      play_i = 1;
      step();
      play_i = 1; pause_i = 1;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         step();
         play_i = 0; pause_i = 0;
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin failures++; $display("FAIL pause_prio cyc=%0d got=%h want=%h", i, got, want); end
      end
      stop_i = 1;
      step();
      stop_i = 0;
   endtask

   task automatic test_default_len();
      setup(0, 0, 0);
      play_i = 1;
      for (int k = 0; k <= 4094; k++) exp_q.push_back(mk(k, (k != 0), 0, 0, 1));
      exp_q.push_back(mk(0, 0, 0, 1, 0));
      for (int i = 0; i <= 4095; i++) begin
         step();
         play_i = 0;
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin failures++; $display("FAIL default_len cyc=%0d got=%h want=%h", i, got, want); end
      end
   endtask

   task automatic test_reset_mid_play();
      setup(0, 0, 1);
      play_i = 1;
      step();
      play_i = 0;
      repeat (1000) step();
      exp_q.push_back(mk(1000, 1, 0, 0, 1));
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL at_1000 got=%h want=%h", got, want); end
      reset = 1; play_i = 1; pause_i = 1;
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      step();
      reset = 0; play_i = 0; pause_i = 0;
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL reset_mid_play got=%h want=%h", got, want); end
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      step();
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL idle_post_reset got=%h want=%h", got, want); end
   endtask

`ifdef BEAT_SEQUENCER_SEEK_EN
   task automatic test_seek();
      setup(10, 3, 1);
      play_i = 1;
      step();
      play_i = 0; pause_i = 1;
      step();
      pause_i = 0;
      seek_i = 1; seek_beat_i = BW'(25);
      exp_q.push_back(mk(9, 1, 0, 0, 0));
      exp_q.push_back(mk(9, 0, 0, 0, 0));
      for (int i = 0; i < 2; i++) begin
         step();
         seek_i = 0;
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin failures++; $display("FAIL seek_pause cyc=%0d got=%h want=%h", i, got, want); end
      end
      play_i = 1;
      step();
      play_i = 0;
      seek_i = 1; seek_beat_i = BW'(4);
      exp_q.push_back(mk(4, 1, 0, 0, 1));
      step();
      seek_i = 0;
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL seek_play got=%h want=%h", got, want); end
      stop_i = 1;
      step();
      stop_i = 0;
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_loop();
      test_oneshot();
      test_pause_resume();
      test_priority();
      test_default_len();
      test_reset_mid_play();
`ifdef BEAT_SEQUENCER_SEEK_EN
      test_seek();
`endif
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
